// File: rtl/escalonador_rodada.sv
// Frame scheduler for astro_genius: runs the per-frame sub-FSMs in order on
// every game tick, with watchdog, overrun flag and asteroid speed division.
module escalonador_rodada #(
  parameter int TICK_CICLOS    = 50_000_000,
  parameter int TIMEOUT_CICLOS = 1024,
  parameter int MOVE_AST_DIV   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic        pausa,
  input  logic        tiro_pendente,
  input  logic        colisao_nave,
  input  logic        fim_reg_tiro,
  input  logic        fim_move_tiros,
  input  logic        fim_compara_tiros,
  input  logic        fim_move_ast,
  input  logic        fim_compara_ast,
  output logic        inicia_reg_tiro,
  output logic        inicia_move_tiros,
  output logic        inicia_compara_tiros,
  output logic        inicia_move_ast,
  output logic        inicia_compara_ast,
  output logic        rodada_pronta,
  output logic        pronto,
  output logic        erro_timeout,
  output logic        db_overrun,
  output logic [3:0]  db_estado,
  output logic [2:0]  db_fase,
  output logic [15:0] db_rodada
);

  localparam int TW = $clog2(TICK_CICLOS);
  localparam int WW = $clog2(TIMEOUT_CICLOS);

  localparam logic [2:0] F_REG   = 3'd0;
  localparam logic [2:0] F_MOV_T = 3'd1;
  localparam logic [2:0] F_CMP_T = 3'd2;
  localparam logic [2:0] F_MOV_A = 3'd3;
  localparam logic [2:0] F_CMP_A = 3'd4;

  typedef enum logic [3:0] {
    S_INICIAL    = 4'd0,
    S_PREPARA    = 4'd1,
    S_ESPERA     = 4'd2,
    S_DISPARA    = 4'd3,
    S_AGUARDA    = 4'd4,
    S_FIM_RODADA = 4'd5,
    S_FIM_JOGO   = 4'd6,
    S_ERRO       = 4'd7
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;
  logic [TW-1:0] r_tick;
  logic [WW-1:0] r_wd;
  logic [15:0]   r_rodada;
  logic [2:0]    r_fase;
  logic          r_pend;
  logic          r_erro;
  logic          r_ovr;

  logic          w_conta;
  logic          w_tick_ok;
  logic          w_tick_fora;
  logic          w_inicio;
  logic          w_fim_atual;
  logic          w_move_ast;
  logic          w_wd_fim;
  logic [2:0]    w_fase_ini;
  logic [2:0]    w_prox_fase;
  logic [15:0]   w_resto;

  assign w_conta = (r_estado == S_ESPERA && !pausa)
                || r_estado == S_DISPARA
                || r_estado == S_AGUARDA
                || r_estado == S_FIM_RODADA;
  assign w_tick_ok   = w_conta && (r_tick == TW'(TICK_CICLOS - 1));
  assign w_tick_fora = w_tick_ok && (r_estado != S_ESPERA);
  // A tick that expired mid-frame starts the next frame right after FIM_RODADA
  assign w_inicio = (r_estado == S_ESPERA || r_estado == S_FIM_RODADA)
                 && (w_tick_ok || r_pend);
  assign w_resto    = r_rodada % 16'(MOVE_AST_DIV);
  assign w_move_ast = (w_resto == '0);
  assign w_wd_fim   = (r_wd == WW'(TIMEOUT_CICLOS - 1));
  assign w_fase_ini = tiro_pendente ? F_REG : F_MOV_T;

  always_comb begin
    w_fim_atual = 1'b0;
    w_prox_fase = F_CMP_A;
    unique case (r_fase)
      F_REG: begin
        w_fim_atual = fim_reg_tiro;
        w_prox_fase = F_MOV_T;
      end
      F_MOV_T: begin
        w_fim_atual = fim_move_tiros;
        w_prox_fase = F_CMP_T;
      end
      F_CMP_T: begin
        w_fim_atual = fim_compara_tiros;
        w_prox_fase = w_move_ast ? F_MOV_A : F_CMP_A;
      end
      F_MOV_A: begin
        w_fim_atual = fim_move_ast;
        w_prox_fase = F_CMP_A;
      end
      default: begin
        w_fim_atual = fim_compara_ast;
        w_prox_fase = F_CMP_A;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= S_INICIAL;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    unique case (r_estado)
      S_INICIAL, S_FIM_JOGO, S_ERRO: begin
        if (iniciar) w_prox = S_PREPARA;
      end
      S_PREPARA: w_prox = S_ESPERA;
      S_ESPERA: begin
        if (w_inicio) w_prox = S_DISPARA;
      end
      S_DISPARA: w_prox = S_AGUARDA;
      S_AGUARDA: begin
        if (w_fim_atual) begin
          if (r_fase == F_CMP_A)
            w_prox = colisao_nave ? S_FIM_JOGO : S_FIM_RODADA;
          else
            w_prox = S_DISPARA;
        end else if (w_wd_fim) begin
          w_prox = S_ERRO;
        end
      end
      S_FIM_RODADA: w_prox = w_inicio ? S_DISPARA : S_ESPERA;
      default: w_prox = S_INICIAL;
    endcase
  end

  always_comb begin
    inicia_reg_tiro      = 1'b0;
    inicia_move_tiros    = 1'b0;
    inicia_compara_tiros = 1'b0;
    inicia_move_ast      = 1'b0;
    inicia_compara_ast   = 1'b0;
    rodada_pronta        = 1'b0;
    pronto               = 1'b0;
    unique case (r_estado)
      S_DISPARA: begin
        inicia_reg_tiro      = (r_fase == F_REG);
        inicia_move_tiros    = (r_fase == F_MOV_T);
        inicia_compara_tiros = (r_fase == F_CMP_T);
        inicia_move_ast      = (r_fase == F_MOV_A);
        inicia_compara_ast   = (r_fase == F_CMP_A);
      end
      S_FIM_RODADA: rodada_pronta = 1'b1;
      S_FIM_JOGO:   pronto = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tick   <= '0;
      r_wd     <= '0;
      r_rodada <= '0;
      r_fase   <= F_REG;
      r_pend   <= 1'b0;
      r_erro   <= 1'b0;
      r_ovr    <= 1'b0;
    end else if (r_estado == S_PREPARA) begin
      r_tick   <= '0;
      r_wd     <= '0;
      r_rodada <= '0;
      r_pend   <= 1'b0;
      r_erro   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_conta)
        r_tick <= w_tick_ok ? '0 : r_tick + 1'b1;
      if (w_inicio)
        r_pend <= 1'b0;
      else if (w_tick_fora)
        r_pend <= 1'b1;
      if (w_tick_fora)
        r_ovr <= 1'b1;
      if (r_estado == S_DISPARA)
        r_wd <= '0;
      else if (r_estado == S_AGUARDA)
        r_wd <= r_wd + 1'b1;
      if (r_estado == S_AGUARDA && w_prox == S_ERRO)
        r_erro <= 1'b1;
      if (r_estado == S_FIM_RODADA)
        r_rodada <= r_rodada + 16'd1;
      if (w_inicio)
        r_fase <= w_fase_ini;
      else if (r_estado == S_AGUARDA && w_fim_atual && r_fase != F_CMP_A)
        r_fase <= w_prox_fase;
    end
  end

  assign erro_timeout = r_erro;
  assign db_overrun   = r_ovr;
  assign db_estado    = r_estado;
  assign db_fase      = r_fase;
  assign db_rodada    = r_rodada;

endmodule

// File: tb/tb_escalonador_rodada.sv
// Bench for escalonador_rodada: frame-queue model checked every cycle plus
// directed scenarios with hand-computed latencies and pulse orders.
`timescale 1ns/1ps
module tb_escalonador_rodada;
  localparam int TICK = 8;
  localparam int TMO  = 16;
  localparam int DIV  = 2;
  localparam int S_INI = 0, S_PREP = 1, S_ESP = 2, S_DIS = 3;
  localparam int S_AGU = 4, S_FIMR = 5, S_FJ = 6, S_ERR = 7;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0;
  logic pausa = 1'b0;
  logic tiro_pendente = 1'b0;
  logic colisao_nave = 1'b0;
  logic [4:0] auto_fim = '0;
  logic [4:0] man_fim = '0;
  logic [4:0] auto_en = 5'h1f;
  logic [4:0] fim;
  assign fim = auto_fim | man_fim;

  logic inicia_reg_tiro, inicia_move_tiros, inicia_compara_tiros;
  logic inicia_move_ast, inicia_compara_ast;
  logic rodada_pronta, pronto, erro_timeout, db_overrun;
  logic [3:0]  db_estado;
  logic [2:0]  db_fase;
  logic [15:0] db_rodada;
  logic [4:0]  inicia;
  logic [31:0] saida;

  assign inicia = {inicia_compara_ast, inicia_move_ast, inicia_compara_tiros,
                   inicia_move_tiros, inicia_reg_tiro};
  assign saida = {inicia, rodada_pronta, pronto, erro_timeout, db_overrun,
                  db_estado, db_fase, db_rodada};

  escalonador_rodada #(
    .TICK_CICLOS(TICK), .TIMEOUT_CICLOS(TMO), .MOVE_AST_DIV(DIV)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .pausa(pausa),
    .tiro_pendente(tiro_pendente), .colisao_nave(colisao_nave),
    .fim_reg_tiro(fim[0]), .fim_move_tiros(fim[1]),
    .fim_compara_tiros(fim[2]), .fim_move_ast(fim[3]),
    .fim_compara_ast(fim[4]),
    .inicia_reg_tiro(inicia_reg_tiro), .inicia_move_tiros(inicia_move_tiros),
    .inicia_compara_tiros(inicia_compara_tiros),
    .inicia_move_ast(inicia_move_ast), .inicia_compara_ast(inicia_compara_ast),
    .rodada_pronta(rodada_pronta), .pronto(pronto),
    .erro_timeout(erro_timeout), .db_overrun(db_overrun),
    .db_estado(db_estado), .db_fase(db_fase), .db_rodada(db_rodada)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  int cyc_n = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clock);
    cyc_n++;
  end

  // Model: a frame is a queue of phases built when the tick fires
  int m_st, m_fase, m_wait, m_rem;
  logic [15:0] m_rod;
  bit m_erro, m_ovr, m_pend;
  int fila[$];

  task automatic m_reset();
    m_st = S_INI; m_fase = 0; m_wait = 0; m_rem = TICK;
    m_rod = '0; m_erro = 0; m_ovr = 0; m_pend = 0;
    fila.delete();
  endtask

  task automatic novo_frame();
    fila.delete();
    if (tiro_pendente) fila.push_back(0);
    fila.push_back(1);
    fila.push_back(2);
    if ((int'(m_rod) % DIV) == 0) fila.push_back(3);
    fila.push_back(4);
    m_fase = fila[0];
    m_st = S_DIS;
  endtask

  task automatic m_step();
    bit ativo, tk;
    ativo = (m_st == S_ESP && !pausa) || m_st == S_DIS
         || m_st == S_AGU || m_st == S_FIMR;
    tk = 0;
    if (ativo) begin
      if (m_rem == 1) begin tk = 1; m_rem = TICK; end
      else m_rem--;
    end
    if (tk && m_st != S_ESP) begin m_ovr = 1; m_pend = 1; end
    case (m_st)
      S_INI, S_FJ, S_ERR: if (iniciar) m_st = S_PREP;
      S_PREP: begin
        m_rem = TICK; m_rod = '0; m_erro = 0; m_ovr = 0; m_pend = 0;
        m_st = S_ESP;
      end
      S_ESP: if (tk || m_pend) begin m_pend = 0; novo_frame(); end
      S_DIS: begin m_wait = 0; m_st = S_AGU; end
      S_AGU: begin
        m_wait++;
        if (fim[fila[0]]) begin
          void'(fila.pop_front());
          if (fila.size() == 0) m_st = colisao_nave ? S_FJ : S_FIMR;
          else begin m_fase = fila[0]; m_st = S_DIS; end
        end else if (m_wait == TMO) begin
          m_st = S_ERR; m_erro = 1;
        end
      end
      S_FIMR: begin
        m_rod = m_rod + 16'd1;
        if (m_pend) begin m_pend = 0; novo_frame(); end
        else m_st = S_ESP;
      end
      default: m_st = S_INI;
    endcase
  endtask

  function automatic logic [31:0] m_saida();
    logic [4:0] ini;
    ini = '0;
    if (m_st == S_DIS) ini[m_fase] = 1'b1;
    return {ini, (m_st == S_FIMR), (m_st == S_FJ), m_erro, m_ovr,
            4'(m_st), 3'(m_fase), m_rod};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clock);
    chk($sformatf("modelo_c%0d", cyc_n), saida, m_saida());
  end

  // Sub-FSM stand-ins: done arrives `atraso` cycles after the start pulse
  int cnt[5];
  int atraso = 3;
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      if (!reset) cnt[i] = 0;
      else if (inicia[i] && auto_en[i]) cnt[i] = atraso;
    end
  end
  initial forever begin
    @(posedge clock);
    #1;
    for (int i = 0; i < 5; i++) begin
      auto_fim[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) auto_fim[i] = 1'b1;
      end
    end
  end

  logic [31:0] seq = '0;
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < 5; i++)
      if (inicia[i]) seq = (seq << 4) | 32'(i + 1);
    if (rodada_pronta) seq = (seq << 4) | 32'hA;
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic bit cond(input int s);
    case (s)
      0: return |inicia;
      1: return rodada_pronta;
      2: return pronto;
      3: return db_estado == 4'd7;
      default: return db_estado == 4'd2;
    endcase
  endfunction

  task automatic espera(input string nm, input int s, input int lim);
    int n;
    n = 0;
    while (!cond(s) && n < lim) begin cyc(); n++; end
    chk(nm, 32'(cond(s)), 32'd1);
  endtask

  task automatic pulso_iniciar();
    iniciar = 1'b1;
    cyc();
    iniciar = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int t0, rp, n, n_ini;
    reset = 1'b0;
    repeat (3) cyc();
    chk("reset_saidas", saida, 32'd0);
    reset = 1'b1;
    repeat (3) cyc();
    chk("inicial_parado", 32'(db_estado), 32'd0);

    tiro_pendente = 1'b0;
    pulso_iniciar();
    chk("prepara", 32'(db_estado), 32'd1);
    cyc();
    chk("espera_tick", 32'(db_estado), 32'd2);
    t0 = cyc_n;
    espera("t1_inicia", 0, 20);
    chk("t1_latencia", 32'(cyc_n - t0), 32'd8);
    chk("t1_move_tiros", 32'(inicia), 32'h02);
    repeat (5) cyc();
    reset = 1'b0;
    #1;
    chk("t1_reset_async", saida, 32'd0);
    cyc();
    reset = 1'b1;

    tiro_pendente = 1'b1;
    pulso_iniciar();
    cyc();
    seq = '0;
    espera("t2_fim_frame0", 1, 100);
    @(negedge clock);
    #1;
    chk("t2_ordem_frame0", seq, 32'h0012_345A);
    chk("t2_overrun", 32'(db_overrun), 32'd1);
    seq = '0;
    cyc();
    chk("t2_rodada1", 32'(db_rodada), 32'd1);
    espera("t2_fim_frame1", 1, 100);
    @(negedge clock);
    #1;
    chk("t2_ordem_frame1", seq, 32'h0001_235A);
    colisao_nave = 1'b1;
    cyc();
    chk("t2_rodada2", 32'(db_rodada), 32'd2);

    rp = 0;
    n = 0;
    while (!pronto && n < 100) begin
      cyc();
      n++;
      if (rodada_pronta) rp++;
    end
    chk("t3_pronto", 32'(pronto), 32'd1);
    chk("t3_sem_rodada_pronta", 32'(rp), 32'd0);
    chk("t3_fim_jogo", 32'({db_estado, db_rodada}), 32'h6_0002);
    colisao_nave = 1'b0;
    tiro_pendente = 1'b0;
    auto_en = 5'b11101;
    pulso_iniciar();
    cyc();
    chk("t3_rodada_zerada", 32'({db_estado, db_rodada}), 32'h2_0000);

    espera("t4_inicia", 0, 20);
    t0 = cyc_n;
    chk("t4_move_tiros", 32'(inicia), 32'h02);
    cyc();
    cyc();
    man_fim = 5'b00100;
    cyc();
    man_fim = '0;
    espera("t4_erro", 3, 40);
    chk("t4_latencia_erro", 32'(cyc_n - t0), 32'd17);
    chk("t4_erro_timeout", 32'(erro_timeout), 32'd1);
    man_fim = 5'b00010;
    cyc();
    man_fim = '0;
    repeat (3) cyc();
    chk("t4_erro_mantido", 32'({erro_timeout, db_estado}), 32'h17);
    auto_en = 5'h1f;

    pulso_iniciar();
    cyc();
    chk("t5_flags_limpos", 32'({erro_timeout, db_overrun}), 32'd0);
    cyc();
    cyc();
    pausa = 1'b1;
    n_ini = 0;
    repeat (20) begin
      cyc();
      if (|inicia) n_ini++;
    end
    chk("t5_sem_inicia", 32'(n_ini), 32'd0);
    chk("t5_ainda_espera", 32'(db_estado), 32'd2);
    pausa = 1'b0;
    t0 = cyc_n;
    espera("t5_inicia", 0, 20);
    chk("t5_restante", 32'(cyc_n - t0), 32'd6);

    reset = 1'b0;
    cyc();
    reset = 1'b1;
    atraso = 10;
    pulso_iniciar();
    cyc();
    espera("t6_fim_frame", 1, 200);
    chk("t6_overrun", 32'(db_overrun), 32'd1);
    cyc();
    chk("t6_inicia_seguinte", 32'(inicia), 32'h02);
    repeat (10) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
